// File: rtl/cfg_serial_driver.sv
// cfg_serial_driver: serialises configuration words onto s_clk/s_data, 5 phases per bit.
// Ports:
//   CLK, resetn          - clock (rising edge) and async active-low reset
//   in_valid/in_ready    - word handshake; in_data (MSB first), in_last (frame end)
//   abort                - synchronous cancel, drops current word and clears word_count
//   s_clk, s_data        - registered serial clock/data
//   busy, done           - not-IDLE indicator, one-cycle frame-complete pulse
//   word_count           - saturating count of completed words
module cfg_serial_driver #(
    parameter int          WORD_W    = 32,
    parameter logic [63:0] CTRL_WORD = 64'h0000_FAB1,
    parameter int          PHASE_CYC = 1,
    parameter int          CNT_W     = 16
) (
    input  logic              CLK,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    input  logic              abort,
    output logic              s_clk,
    output logic              s_data,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  word_count
);
    localparam int              BW   = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [WORD_W-1:0] CTRL = CTRL_WORD[WORD_W-1:0];
    localparam logic [8:0]      PH   = 9'(PHASE_CYC);
    localparam logic [8:0]      PH3  = 9'(2 * PHASE_CYC);

    typedef enum logic [2:0] {IDLE, P0, P1, P2, P3} state_t;

    state_t            state_q, state_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [8:0]        cyc_q, cyc_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              last_q, last_d;
    logic              fresh_q, fresh_d;
    logic              s_clk_q, s_clk_d;
    logic              s_data_q, s_data_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              ph_end, fin;

    always_comb begin
        ph_end   = cyc_q == ((state_q == P3) ? PH3 : PH) - 9'd1;
        fin      = state_q == P3 && ph_end && bit_q == '0;
        in_ready = state_q == IDLE || (fin && !last_q);
        cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        state_d  = state_q;
        bit_d    = bit_q;
        cyc_d    = (state_q == IDLE) ? 9'd0 : cyc_q + 9'd1;
        word_d   = word_q;
        last_d   = last_q;
        fresh_d  = fresh_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        if (abort) begin
            state_d = IDLE;
            bit_d   = '0;
            cyc_d   = '0;
            cnt_d   = '0;
            fresh_d = 1'b0;
        end else if (in_valid && in_ready) begin
            state_d = P0;
            bit_d   = BW'(WORD_W - 1);
            cyc_d   = '0;
            word_d  = in_data;
            last_d  = in_last;
            fresh_d = 1'b0;
            // fresh_q marks that a frame finished: the next accepted word starts a new count
            cnt_d   = fin ? cnt_inc : fresh_q ? '0 : cnt_q;
        end else if (state_q != IDLE && ph_end) begin
            cyc_d = '0;
            if (state_q != P3) begin
                state_d = (state_q == P0) ? P1 : (state_q == P1) ? P2 : P3;
            end else if (bit_q != '0) begin
                state_d = P0;
                bit_d   = bit_q - BW'(1);
            end else begin
                state_d = IDLE;
                cnt_d   = cnt_inc;
                done_d  = last_q;
                fresh_d = last_q;
            end
        end
        // Outputs are registered, so derive them from the state being entered
        s_clk_d  = state_d == P1 || state_d == P2;
        s_data_d = (state_d == P0 || state_d == P1) ? word_d[bit_d] :
                   (state_d == P2 || state_d == P3) ? CTRL[bit_d] : 1'b0;
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            bit_q    <= '0;
            cyc_q    <= '0;
            word_q   <= '0;
            last_q   <= 1'b0;
            fresh_q  <= 1'b0;
            s_clk_q  <= 1'b0;
            s_data_q <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            bit_q    <= bit_d;
            cyc_q    <= cyc_d;
            word_q   <= word_d;
            last_q   <= last_d;
            fresh_q  <= fresh_d;
            s_clk_q  <= s_clk_d;
            s_data_q <= s_data_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
        end
    end

    assign s_clk      = s_clk_q;
    assign s_data     = s_data_q;
    assign busy       = state_q != IDLE;
    assign done       = done_q;
    assign word_count = cnt_q;
endmodule

// File: tb/tb_cfg_serial_driver.sv
// tb_cfg_serial_driver: directed bench with a cycle-offset model for the default instance.
module tb_cfg_serial_driver;
    localparam int          W  = 32;
    localparam int          P  = 1;
    localparam int          L  = 5 * P * W;
    localparam logic [31:0] CT = 32'h0000_FAB1;

    logic        CLK = 1'b0, resetn = 1'b0;
    logic        v0 = 1'b0, l0 = 1'b0, a0 = 1'b0;
    logic [31:0] d0 = '0;
    logic        rdy0, sc0, sd0, bz0, dn0;
    logic [15:0] wc0;
    logic        v1 = 1'b0, l1 = 1'b0, a1 = 1'b0;
    logic [7:0]  d1 = '0;
    logic        rdy1, sc1, sd1, bz1, dn1;
    logic [1:0]  wc1;

    always #5 CLK = ~CLK;

    cfg_serial_driver u0 (
        .CLK(CLK), .resetn(resetn), .in_valid(v0), .in_ready(rdy0), .in_data(d0),
        .in_last(l0), .abort(a0), .s_clk(sc0), .s_data(sd0), .busy(bz0), .done(dn0),
        .word_count(wc0)
    );

    cfg_serial_driver #(.WORD_W(8), .PHASE_CYC(3), .CNT_W(2)) u1 (
        .CLK(CLK), .resetn(resetn), .in_valid(v1), .in_ready(rdy1), .in_data(d1),
        .in_last(l1), .abort(a1), .s_clk(sc1), .s_data(sd1), .busy(bz1), .done(dn1),
        .word_count(wc1)
    );

    int tests = 0, fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: bound expired, got no event want event", nm);
    endtask

    // Model: a word is an offset k in 0..L-1 from its first serial cycle
    logic        m_busy = 0, m_last = 0, m_fresh = 0, m_done = 0;
    int          m_k = 0;
    logic [31:0] m_word = '0, ct_v = CT;
    logic [15:0] m_cnt = '0;

    always @(posedge CLK) begin : model
        logic rdy;
        rdy    = !m_busy || (m_k == L - 1 && !m_last);
        m_done = 1'b0;
        if (!resetn) begin
            m_busy = 0; m_k = 0; m_last = 0; m_fresh = 0; m_cnt = '0;
        end else if (a0) begin
            m_busy = 0; m_cnt = '0; m_fresh = 0;
        end else if (m_busy && m_k < L - 1) begin
            m_k++;
        end else begin
            if (m_busy) begin
                m_cnt  = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
                m_busy = 0;
                if (m_last) begin m_done = 1; m_fresh = 1; end
            end
            if (v0 && rdy) begin
                if (m_fresh) m_cnt = '0;
                m_fresh = 0; m_busy = 1; m_k = 0; m_word = d0; m_last = l0;
            end
        end
    end

    // Monitors
    int          cyc = 0, busy_cnt = 0, done_cnt = 0, start_cyc = 0, done_cyc = 0;
    logic [31:0] rise_sh = '0, fall_sh = '0;
    logic        pclk = 0, pdat = 0, pbz = 0;
    int          busy1_cnt = 0, done1_cnt = 0, hi1_cnt = 0, rises1 = 0, bad1 = 0, hi_run1 = 0, lo_run1 = 0;
    logic        lo_gap1 = 1, pclk1 = 0;
    logic [7:0]  rise1_sh = '0;

    always @(posedge CLK) begin : compare
        int r, b;
        logic e_clk, e_dat;
        #1;
        if (m_busy) begin
            r     = m_k % (5 * P);
            b     = W - 1 - m_k / (5 * P);
            e_clk = r >= P && r < 3 * P;
            e_dat = (r < 2 * P) ? m_word[b] : ct_v[b];
        end else begin
            e_clk = 0;
            e_dat = 0;
        end
        chk("mdl_busy", bz0, m_busy);
        chk("mdl_s_clk", sc0, e_clk);
        chk("mdl_s_data", sd0, e_dat);
        chk("mdl_done", dn0, m_done);
        chk("mdl_word_count", wc0, m_cnt);
        chk("mdl_in_ready", rdy0, !m_busy || (m_k == L - 1 && !m_last));
        cyc++;
        if (bz0) busy_cnt++;
        if (bz0 && !pbz) start_cyc = cyc;
        if (dn0) begin done_cnt++; done_cyc = cyc; end
        if (sc0 && !pclk) rise_sh = {rise_sh[30:0], sd0};
        if (!sc0 && pclk) fall_sh = {fall_sh[30:0], pdat};
        pclk = sc0; pdat = sd0; pbz = bz0;
        if (bz1) busy1_cnt++;
        if (dn1) done1_cnt++;
        if (!bz1 && !sc1) lo_gap1 = 1;
        if (sc1) begin
            hi1_cnt++;
            if (!pclk1) begin
                if (!lo_gap1 && lo_run1 != 9) bad1++;
                lo_gap1  = 0;
                rises1++;
                rise1_sh = {rise1_sh[6:0], sd1};
                hi_run1  = 0;
            end
            hi_run1++;
        end else begin
            if (pclk1) begin
                if (hi_run1 != 6) bad1++;
                lo_run1 = 0;
            end
            lo_run1++;
        end
        pclk1 = sc1;
    end

    task automatic send0(input logic [31:0] d, input logic l);
        int n = 0;
        d0 = d; l0 = l; v0 = 1;
        while (!rdy0 && n < 2000) begin @(negedge CLK); n++; end
        if (n >= 2000) tmo("send0");
        @(negedge CLK);
    endtask

    task automatic wait_done0(input int mx);
        int n = 0;
        while (!dn0 && n < mx) begin @(negedge CLK); n++; end
        if (n >= mx) tmo("done0");
    endtask

    task automatic send1(input logic [7:0] d, input logic l);
        int n = 0;
        d1 = d; l1 = l; v1 = 1;
        while (!rdy1 && n < 2000) begin @(negedge CLK); n++; end
        if (n >= 2000) tmo("send1");
        @(negedge CLK);
    endtask

    task automatic wait_done1(input int mx);
        int n = 0;
        while (!dn1 && n < mx) begin @(negedge CLK); n++; end
        if (n >= mx) tmo("done1");
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        int bb, bd, bh, br, bbad;
        repeat (3) @(negedge CLK);
        resetn = 1;
        #1;
        chk("rst_in_ready", rdy0, 1);
        chk("rst_busy", bz0, 0);
        chk("rst_s_clk", sc0, 0);
        chk("rst_s_data", sd0, 0);
        chk("rst_done", dn0, 0);
        chk("rst_word_count", wc0, 0);
        @(negedge CLK);
        // single word, in_last=1
        bb = busy_cnt; bd = done_cnt;
        send0(32'hA500_0000, 1); v0 = 0;
        wait_done0(400);
        chk("w1_count", wc0, 1);
        chk("w1_rise_bits", rise_sh, 32'hA500_0000);
        chk("w1_fall_bits", fall_sh, 32'h0000_FAB1);
        chk("w1_busy_cycles", busy_cnt - bb, 160);
        chk("w1_span", done_cyc - start_cyc, 160);
        @(negedge CLK);
        chk("w1_done_once", done_cnt - bd, 1);
        chk("w1_done_low", dn0, 0);
        // three back-to-back words, accepted fresh after a done
        bb = busy_cnt; bd = done_cnt;
        send0(32'h1234_5678, 0);
        send0(32'h9ABC_DEF0, 0);
        send0(32'h0F0F_0F0F, 1); v0 = 0;
        wait_done0(1000);
        chk("w3_count", wc0, 3);
        chk("w3_busy_cycles", busy_cnt - bb, 480);
        chk("w3_span", done_cyc - start_cyc, 480);
        chk("w3_done_once", done_cnt - bd, 1);
        // word accepted in the done cycle restarts the count
        send0(32'hFFFF_FFFF, 1); v0 = 0;
        chk("fresh_cleared", wc0, 0);
        wait_done0(400);
        chk("fresh_count", wc0, 1);
        @(negedge CLK);
        // abort at cycle 50 of the second word of a frame
        send0(32'hC3C3_C3C3, 0);
        send0(32'h3C3C_3C3C, 1); v0 = 0;
        bd = done_cnt;
        repeat (49) @(negedge CLK);
        chk("abort_pre_count", wc0, 1);
        chk("abort_pre_busy", bz0, 1);
        a0 = 1;
        @(posedge CLK); #1;
        chk("abort_busy", bz0, 0);
        chk("abort_s_clk", sc0, 0);
        chk("abort_s_data", sd0, 0);
        chk("abort_count", wc0, 0);
        @(negedge CLK); a0 = 0;
        repeat (200) @(negedge CLK);
        chk("abort_no_done", done_cnt - bd, 0);
        send0(32'h8000_0001, 1); v0 = 0;
        wait_done0(400);
        chk("post_abort_count", wc0, 1);
        @(negedge CLK);
        a0 = 1;
        @(negedge CLK); a0 = 0;
        chk("idle_abort_count", wc0, 0);
        // reset at cycle 70 of a word
        send0(32'h1111_1111, 0);
        send0(32'hDEAD_BEEF, 1); v0 = 0;
        repeat (69) @(negedge CLK);
        chk("rmid_pre_busy", bz0, 1);
        chk("rmid_pre_count", wc0, 1);
        #2 resetn = 0;
        #1;
        chk("rmid_busy", bz0, 0);
        chk("rmid_count", wc0, 0);
        chk("rmid_s_clk", sc0, 0);
        chk("rmid_s_data", sd0, 0);
        chk("rmid_done", dn0, 0);
        @(negedge CLK); @(negedge CLK);
        resetn = 1;
        #1;
        chk("rrel_in_ready", rdy0, 1);
        chk("rrel_busy", bz0, 0);
        repeat (20) @(negedge CLK);
        chk("rrel_no_resume", bz0, 0);
        // WORD_W=8, PHASE_CYC=3 instance
        bb = busy1_cnt; bd = done1_cnt; bh = hi1_cnt; br = rises1; bbad = bad1;
        send1(8'hA7, 1); v1 = 0;
        wait_done1(400);
        chk("p3_count", wc1, 1);
        chk("p3_busy_cycles", busy1_cnt - bb, 120);
        chk("p3_high_cycles", hi1_cnt - bh, 48);
        chk("p3_rises", rises1 - br, 8);
        chk("p3_bits", rise1_sh, 8'hA7);
        chk("p3_run_lengths", bad1 - bbad, 0);
        @(negedge CLK);
        chk("p3_done_once", done1_cnt - bd, 1);
        // five words on a 2-bit counter saturate at 3
        bb = busy1_cnt; bd = done1_cnt; bbad = bad1;
        send1(8'h01, 0);
        send1(8'h02, 0);
        send1(8'h04, 0);
        send1(8'h08, 0);
        send1(8'h10, 1); v1 = 0;
        wait_done1(1200);
        chk("sat_count", wc1, 3);
        chk("sat_busy_cycles", busy1_cnt - bb, 600);
        chk("sat_done_once", done1_cnt - bd, 1);
        chk("sat_run_lengths", bad1 - bbad, 0);
        repeat (3) @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
